// File: rtl/wb_trace_buffer.sv
// Commit-trace buffer: captures register write-backs and data-memory stores from the
// single-cycle MIPS core into a record FIFO. Each record is sent as a three-word
// ready/valid stream: pc, {kind, addr[30:0]}, data.
module wb_trace_buffer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_trace_en,
    input  logic                      i_clr_stats,
    input  logic [31:0]               i_pc,
    input  logic                      i_reg_we,
    input  logic [4:0]                i_reg_addr,
    input  logic [31:0]               i_reg_data,
    input  logic                      i_mem_we,
    input  logic [31:0]               i_mem_addr,
    input  logic [31:0]               i_mem_data,
    output logic                      o_out_valid,
    output logic [31:0]               o_out_data,
    output logic                      o_out_last,
    input  logic                      i_out_ready,
    output logic [$clog2(DEPTH):0]    o_fill_level,
    output logic [15:0]               o_drop_count,
    output logic                      o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Record layout: [95] kind, [94:63] pc, [62:32] addr[30:0], [31:0] data.
    localparam int unsigned RW = 96;

    typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

    // Record storage and pointers; the extra MSB separates full from empty.
    logic [RW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [RW-1:0] r_hold;
    state_e        r_state;
    state_e        w_state_next;
    logic [15:0]   r_drop_count;
    logic          r_overflow;

    logic          w_store_ev;
    logic          w_reg_ev;
    logic          w_event;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [RW-1:0] w_rec;
    logic [1:0]    w_drops;
    logic [16:0]   w_drop_sum;
    logic          w_unused_addr31;

    // Store addresses live below 2^31, so bit 31 is never carried into the stream.
    assign w_unused_addr31 = i_mem_addr[31];

    // Event qualification; writes to $0 are not events at all.
    assign w_store_ev = i_trace_en & i_mem_we;
    assign w_reg_ev   = i_trace_en & i_reg_we & (i_reg_addr != 5'd0);
    assign w_event    = w_store_ev | w_reg_ev;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Fullness is the pre-edge view: a same-edge pop does not make room for a push.
    assign w_push = w_event & ~w_full;

    // A store wins over a simultaneous register write-back.
    always_comb begin
        w_rec = '0;
        if (w_store_ev) begin
            w_rec = {1'b1, i_pc, i_mem_addr[30:0], i_mem_data};
        end else begin
            w_rec = {1'b0, i_pc, 26'd0, i_reg_addr, i_reg_data};
        end
    end

    // Up to two drops per edge: the losing register event, and the event refused when full.
    assign w_drops    = {1'b0, w_store_ev & w_reg_ev} + {1'b0, w_event & w_full};
    assign w_drop_sum = {1'b0, r_drop_count} + {15'd0, w_drops};

    // Record storage write port; contents need no reset since pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_rec;
        end
    end

    // FIFO pointers advance on push/pop and wrap naturally through the extra bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Holding register for the record currently being serialized.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_pop) begin
            r_hold <= r_mem[r_rptr[AW-1:0]];
        end
    end

    // Drop statistics; a clear takes priority and swallows any drop on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (i_clr_stats) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_drops != 2'd0) begin
            r_overflow   <= 1'b1;
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    // Serializer state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Serializer next-state, pop request and stream outputs.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        o_out_valid  = 1'b0;
        o_out_data   = 32'd0;
        o_out_last   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StW0;
                end
            end
            StW0: begin
                o_out_valid = 1'b1;
                o_out_data  = r_hold[94:63];
                if (i_out_ready) begin
                    w_state_next = StW1;
                end
            end
            StW1: begin
                o_out_valid = 1'b1;
                o_out_data  = {r_hold[95], r_hold[62:32]};
                if (i_out_ready) begin
                    w_state_next = StW2;
                end
            end
            StW2: begin
                o_out_valid = 1'b1;
                o_out_data  = r_hold[31:0];
                o_out_last  = 1'b1;
                if (i_out_ready) begin
                    // Chain straight into the next record to avoid an idle bubble.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StW0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_fill_level = r_wptr - r_rptr;
    assign o_drop_count = r_drop_count;
    assign o_overflow   = r_overflow;

endmodule
